// File: rtl/sr_wb_pkg.sv
// Shared types and widths for the writeback unit: data/address widths and the
// MDU result entry that travels through the result FIFO.
package sr_wb_pkg;

  localparam int XLEN  = 32;
  localparam int RA_W  = 5;
  localparam int NREGS = 1 << RA_W;

  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] wd;
  } wb_entry_t;

endpackage

// File: rtl/sr_wb_fifo.sv
// Small synchronous FIFO holding MDU results until the writeback port is free.
// Head entry is presented combinationally on dout; no bypass when empty.
module sr_wb_fifo
  import sr_wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  wb_entry_t       din,
  output wb_entry_t       dout,
  output logic [CW-1:0]   count,
  output logic            full,
  output logic            empty
);

  wb_entry_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH by themselves.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
    end
  end

  // NOTE: storage is deliberately not reset; validity comes only from the
  // pointers and count, which lets the array map onto plain RAM/flops without reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/sr_writeback_unit.sv
// Writeback stage: ALU results win the register-file port, buffered MDU results
// fill idle cycles, and a pending scoreboard stalls decode on outstanding MDU rds.
module sr_writeback_unit
  import sr_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic [RA_W-1:0]  alu_rd,
  input  logic [XLEN-1:0]  alu_wd,
  input  logic             mdu_issue,
  input  logic [RA_W-1:0]  mdu_issue_rd,
  input  logic             mdu_valid,
  output logic             mdu_ready,
  input  logic [RA_W-1:0]  mdu_rd,
  input  logic [XLEN-1:0]  mdu_wd,
  input  logic [RA_W-1:0]  q_rs1,
  input  logic [RA_W-1:0]  q_rs2,
  input  logic [RA_W-1:0]  q_rd,
  output logic             hazard,
  output logic             rf_we,
  output logic [RA_W-1:0]  rf_a,
  output logic [XLEN-1:0]  rf_wd
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t        w_din;
  wb_entry_t        w_head;
  logic [CW-1:0]    w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_alu_sel;
  logic             r_rf_we;
  logic [RA_W-1:0]  r_rf_a;
  logic [XLEN-1:0]  r_rf_wd;
  logic [NREGS-1:0] r_pending;
  logic [NREGS-1:0] w_pending_nxt;

  // A write to x0 is not a real write, so it must not steal the port from the FIFO.
  assign w_alu_sel = alu_valid && (alu_rd != '0);
  assign w_pop     = !w_empty && !w_alu_sel;
  assign mdu_ready = !rst && (w_count < CW'(DEPTH));
  assign w_push    = mdu_valid && mdu_ready && !w_full;
  assign w_din     = '{rd: mdu_rd, wd: mdu_wd};

  sr_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_we <= 1'b0;
      r_rf_a  <= '0;
      r_rf_wd <= '0;
    end else if (w_alu_sel) begin
      r_rf_we <= 1'b1;
      r_rf_a  <= alu_rd;
      r_rf_wd <= alu_wd;
    end else if (w_pop) begin
      r_rf_we <= (w_head.rd != '0);
      r_rf_a  <= w_head.rd;
      r_rf_wd <= w_head.wd;
    end else begin
      r_rf_we <= 1'b0;
    end
  end

  // NOTE: always_comb uses blocking '=' so later lines see earlier updates (set
  // after clear makes set win); always_ff uses '<=' so flops sample together.
  always_comb begin
    // NOTE: copying the current state first gives every bit a value on every
    // path, which is what keeps this block from inferring latches.
    w_pending_nxt = r_pending;
    if (w_pop) w_pending_nxt[w_head.rd] = 1'b0;
    if (mdu_issue && (mdu_issue_rd != '0)) w_pending_nxt[mdu_issue_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_pending <= '0;
    else     r_pending <= w_pending_nxt;
  end

  assign hazard = r_pending[q_rs1] | r_pending[q_rs2] | r_pending[q_rd];
  assign rf_we  = r_rf_we;
  assign rf_a   = r_rf_a;
  assign rf_wd  = r_rf_wd;

endmodule
